// File: rtl/vc_crossbar4_alloc_pkg.sv
// Shared types for the 4x4 crossbar allocator.
//   NPORTS   : port count (fixed at 4)
//   DEST_W   : width of a destination/input index
//   NDOMAINS : security domains, one round-robin pointer bank each
//   idx_t    : 2-bit port index / pointer
//   dom_t    : security domain tag
//   lock_t   : per-output grant lock (valid, locked input, owning domain)
package vc_crossbar4_alloc_pkg;
   localparam int NPORTS   = 4;
   localparam int DEST_W   = 2;
   localparam int NDOMAINS = 2;
   localparam int SD_W     = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1;

   typedef logic [DEST_W-1:0] idx_t;
   typedef logic [SD_W-1:0]   dom_t;

   typedef struct packed {
      logic vld;
      idx_t idx;
      dom_t sd;
   } lock_t;
endpackage

// File: rtl/vc_crossbar4_alloc_if.sv
// Handshake bundle between the input/output ports and the allocator.
//   sd         : current security domain
//   in_val     : per-input request valid
//   in_dest    : 2-bit destination per input, {in3,in2,in1,in0}
//   in_rdy     : per-input accept
//   out_val    : per-output valid
//   out_rdy    : per-output downstream ready
//   sel0..sel3 : crossbar select, input index routed to output j
// slave = allocator side, master = port/crossbar side.
interface vc_crossbar4_alloc_if;
   import vc_crossbar4_alloc_pkg::*;
   dom_t       sd;
   logic [3:0] in_val;
   logic [7:0] in_dest;
   logic [3:0] in_rdy;
   logic [3:0] out_val;
   logic [3:0] out_rdy;
   idx_t       sel0, sel1, sel2, sel3;

   modport slave  (input  sd, in_val, in_dest, out_rdy,
                   output in_rdy, out_val, sel0, sel1, sel2, sel3);
   modport master (output sd, in_val, in_dest, out_rdy,
                   input  in_rdy, out_val, sel0, sel1, sel2, sel3);
endinterface

// File: rtl/vc_crossbar4_alloc_rr_arb4.sv
// Combinational 4-way round-robin select.
//   req     : request per input
//   ptr     : highest-priority input
//   gnt_val : some input requests
//   gnt_idx : first requester at or after ptr (mod 4), 0 when none
module vc_rr_arb4
   import vc_crossbar4_alloc_pkg::*;
(
   input  logic [3:0] req,
   input  idx_t       ptr,
   output logic       gnt_val,
   output idx_t       gnt_idx
);
   idx_t cand;

   // Walk from farthest to nearest so the candidate closest to ptr wins.
   always_comb begin
      gnt_val = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + idx_t'(k);
         if (req[cand]) begin
            gnt_val = 1'b1;
            gnt_idx = cand;
         end
      end
   end
endmodule

// File: rtl/vc_crossbar4_alloc.sv
// Control side of the 4x4 crossbar: allocates outputs to requesting inputs.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see vc_crossbar4_alloc_if
// Per output: round-robin over inputs, pointer banked by security domain,
// grant locked while the output stalls. All outputs are combinational.
module vc_crossbar4_alloc
   import vc_crossbar4_alloc_pkg::*;
#(
   parameter int p_ndomains = NDOMAINS,
   parameter int p_nports   = NPORTS
) (
   input logic                 clk,
   input logic                 reset,
   vc_crossbar4_alloc_if.slave bus
);
   // ptr_q[d][j]: highest-priority input for output j in domain d
   idx_t  [p_ndomains-1:0][p_nports-1:0] ptr_q;
   lock_t [p_nports-1:0]                 lock_q;

   logic  [p_nports-1:0][p_nports-1:0]   req_m;   // [output][input]
   idx_t  [p_nports-1:0]                 cur_ptr;
   logic  [p_nports-1:0]                 rr_val, gnt_val, lock_hit;
   idx_t  [p_nports-1:0]                 rr_idx, gnt_idx, sel_a;
   logic  [p_nports-1:0]                 out_val;
   idx_t                                 d;

   always_comb begin
      req_m = '0;
      for (int j = 0; j < p_nports; j++)
         for (int i = 0; i < p_nports; i++)
            req_m[j][i] = bus.in_val[i] && (bus.in_dest[2*i +: 2] == idx_t'(j));
   end

   assign cur_ptr = ptr_q[bus.sd];

   vc_rr_arb4 u_arb [p_nports-1:0] (
      .req     (req_m),
      .ptr     (cur_ptr),
      .gnt_val (rr_val),
      .gnt_idx (rr_idx)
   );

   // A lock from another domain is invisible; a lock whose owner dropped
   // val yields no grant (and is cleared below).
   always_comb begin
      lock_hit = '0;
      gnt_val  = '0;
      gnt_idx  = '0;
      out_val  = '0;
      sel_a    = '0;
      for (int j = 0; j < p_nports; j++) begin
         lock_hit[j] = lock_q[j].vld && (lock_q[j].sd == bus.sd);
         gnt_val[j]  = lock_hit[j] ? req_m[j][lock_q[j].idx] : rr_val[j];
         gnt_idx[j]  = lock_hit[j] ? lock_q[j].idx : rr_idx[j];
         out_val[j]  = reset && gnt_val[j];
         sel_a[j]    = out_val[j] ? gnt_idx[j] : '0;
      end
   end

   always_comb begin
      bus.in_rdy = '0;
      d          = '0;
      for (int i = 0; i < p_nports; i++) begin
         d = bus.in_dest[2*i +: 2];
         bus.in_rdy[i] = bus.in_val[i] && out_val[d] && (sel_a[d] == idx_t'(i))
                         && bus.out_rdy[d];
      end
   end

   assign bus.out_val = out_val;
   assign bus.sel0    = sel_a[0];
   assign bus.sel1    = sel_a[1];
   assign bus.sel2    = sel_a[2];
   assign bus.sel3    = sel_a[3];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q  <= '0;
         lock_q <= '0;
      end else begin
         for (int j = 0; j < p_nports; j++) begin
            if (gnt_val[j] && bus.out_rdy[j]) begin
               ptr_q[bus.sd][j] <= gnt_idx[j] + idx_t'(1);
               lock_q[j].vld    <= 1'b0;
            end else if (gnt_val[j]) begin
               lock_q[j] <= '{vld: 1'b1, idx: gnt_idx[j], sd: bus.sd};
            end else if (lock_hit[j]) begin
               lock_q[j].vld <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_vc_crossbar4_alloc.sv
// Bench for vc_crossbar4_alloc: directed scenarios then random traffic,
// expected handshake values queued by the driver, compared by a monitor.
module tb_vc_crossbar4_alloc;
   import vc_crossbar4_alloc_pkg::*;

   typedef struct packed {
      logic [3:0] oval;
      logic [7:0] sel;
      logic [3:0] irdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   errs  = 0;
   exp_t q[$];

   // reference state: plain integers per domain / output
   int ptr_m [2][4];
   bit lk_on [4];
   int lk_in [4];
   int lk_dom[4];

   vc_crossbar4_alloc_if bus();

   vc_crossbar4_alloc #(.p_ndomains(2), .p_nports(4)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
      tests++;
      if (a !== x) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
      end
   endtask

   // Apply one cycle of inputs, queue the expected response, then advance
   // the reference state as if the coming rising edge happened.
   task automatic step(input bit r, input int s, input logic [3:0] v,
                       input logic [7:0] dst, input logic [3:0] o);
      exp_t e;
      bit   gv[4];
      int   gi[4];
      int   dj;
      @(posedge clk); #2;
      rst_n       = r;
      bus.sd      = dom_t'(s);
      bus.in_val  = v;
      bus.in_dest = dst;
      bus.out_rdy = o;
      for (int j = 0; j < 4; j++) begin
         gv[j] = 0;
         gi[j] = 0;
         if (lk_on[j] && lk_dom[j] == s) begin
            if (v[lk_in[j]] && int'(dst[2*lk_in[j] +: 2]) == j) begin
               gv[j] = 1;
               gi[j] = lk_in[j];
            end
         end else begin
            for (int k = 0; k < 4; k++) begin
               int i;
               i = (ptr_m[s][j] + k) % 4;
               if (!gv[j] && v[i] && int'(dst[2*i +: 2]) == j) begin
                  gv[j] = 1;
                  gi[j] = i;
               end
            end
         end
      end
      e = '0;
      if (r) begin
         for (int j = 0; j < 4; j++) begin
            e.oval[j] = gv[j];
            if (gv[j]) e.sel[2*j +: 2] = 2'(gi[j]);
         end
         for (int i = 0; i < 4; i++) begin
            dj = int'(dst[2*i +: 2]);
            e.irdy[i] = v[i] && gv[dj] && gi[dj] == i && o[dj];
         end
      end
      q.push_back(e);
      if (!r) begin
         for (int j = 0; j < 4; j++) begin
            lk_on[j] = 0;
            ptr_m[0][j] = 0;
            ptr_m[1][j] = 0;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (gv[j] && o[j]) begin
               ptr_m[s][j] = (gi[j] + 1) % 4;
               lk_on[j] = 0;
            end else if (gv[j]) begin
               lk_on[j] = 1; lk_in[j] = gi[j]; lk_dom[j] = s;
            end else if (lk_on[j] && lk_dom[j] == s) begin
               lk_on[j] = 0;
            end
         end
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_val", {4'b0, bus.out_val}, {4'b0, e.oval});
            chk("sel", {bus.sel3, bus.sel2, bus.sel1, bus.sel0}, e.sel);
            chk("in_rdy", {4'b0, bus.in_rdy}, {4'b0, e.irdy});
         end
      end
   end

   initial begin
      int sd_r = 0;
      bus.sd = '0; bus.in_val = '0; bus.in_dest = '0; bus.out_rdy = '0;
      // held in reset with live requests: everything forced low
      step(0, 0, 4'hf, 8'h55, 4'hf);
      step(0, 0, 4'hf, 8'h55, 4'hf);
      // all inputs to output 1: sel1 0,1,2,3,0
      repeat (5) step(1, 0, 4'hf, 8'h55, 4'hf);
      // inputs 1,3 to output 2, stall 3 cycles, then fire twice
      repeat (3) step(1, 0, 4'b1010, {2'd2, 2'd0, 2'd2, 2'd0}, 4'b1011);
      repeat (2) step(1, 0, 4'b1010, {2'd2, 2'd0, 2'd2, 2'd0}, 4'b1111);
      // full permutation
      repeat (3) step(1, 0, 4'hf, {2'd0, 2'd3, 2'd2, 2'd1}, 4'hf);
      // domain isolation on output 0
      step(1, 0, 4'b0001, 8'h00, 4'hf);
      step(1, 0, 4'b0010, 8'h00, 4'hf);
      step(1, 1, 4'b0101, 8'h00, 4'hf);
      step(1, 0, 4'b0101, 8'h00, 4'hf);
      // lock output 3 on input 2, reset mid-stall, then fresh arbitration
      repeat (2) step(1, 0, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0111);
      step(0, 0, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0111);
      step(1, 0, 4'b0101, {2'd0, 2'd3, 2'd0, 2'd3}, 4'hf);
      // locked input drops val during stall, then round-robin resumes
      step(1, 0, 4'b0010, {2'd2, 2'd0, 2'd2, 2'd0}, 4'b1011);
      step(1, 0, 4'b0000, {2'd2, 2'd0, 2'd2, 2'd0}, 4'b1011);
      step(1, 0, 4'b1010, {2'd2, 2'd0, 2'd2, 2'd0}, 4'hf);
      // lock in domain 1, then seen from domain 0
      step(1, 1, 4'b0001, 8'h00, 4'b1110);
      step(1, 0, 4'b0011, 8'h00, 4'b1110);
      step(1, 1, 4'b0011, 8'h00, 4'hf);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) sd_r = 1 - sd_r;
         step($urandom_range(0, 49) != 0, sd_r, 4'($urandom),
              8'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hf);
      end
      @(posedge clk);
      @(posedge clk);
      tests++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule

// File: doc/vc_crossbar4_alloc.md
Name: vc_crossbar4_alloc

Overview:
- Control-side companion of the 4x4 datapath crossbar: accepts val/rdy requests from 4 input ports, each tagged with a destination output, and allocates outputs.
- Drives the crossbar's sel0..sel3 and the per-port val/rdy handshakes.
- Round-robin fairness per output, with grant locking while an output is stalled.
- Priority state is banked per security domain so one domain's arbitration history never influences another's.

Parameters:
- p_ndomains, 2, number of security domains; one round-robin pointer bank per domain.
- p_nports, 4, port count; fixed at 4 for this block, other values unsupported.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sd  input  clog2(p_ndomains)  current security domain; selects the pointer bank.
- in_val  input  4  per-input request valid.
- in_dest  input  8  2-bit destination output per input, {in3,in2,in1,in0}.
- in_rdy  output  4  per-input accept.
- out_val  output  4  per-output valid.
- out_rdy  input  4  per-output downstream ready.
- sel0..sel3  output  2 each  crossbar select: index of the input routed to output j.

Behaviour:
- Request matrix: req[i][j] = in_val[i] && in_dest[i]==j. Each input requests at most one output, so inputs never conflict.
- Arbitration: for each output j, ptr[sd][j] (2 bits) is the highest-priority input. Search order is ptr, ptr+1, ... mod 4. The grant is the first requesting input found.
- Lock: if lock_vld[j] && lock_sd[j]==sd, the grant is lock_idx[j] and the pointer is ignored.
  - The lock is honoured only while req[lock_idx][j] stays high.
  - If the locked input drops val (protocol violation), out_val[j]=0 that cycle and the lock clears at the next edge.
- Outputs are combinational; zero cycles from request to out_val/sel/in_rdy:
  - out_val[j] = any grant on j.
  - sel_j = granted index, or 0 when there is no grant.
  - in_rdy[i] = granted on in_dest[i] && out_rdy[in_dest[i]].
- State update on the rising edge, per output j:
  - Fire (out_val[j] && out_rdy[j]): ptr[sd][j] <= grant+1 mod 4; lock_vld[j] <= 0.
  - Stall (out_val[j] && !out_rdy[j]): lock_vld[j] <= 1, lock_idx[j] <= grant, lock_sd[j] <= sd.
  - Idle: state unchanged.
- Pointer wrap-around: a grant to input 3 sets ptr to 0.
- Domain switch: a lock tagged with another domain is ignored and is overwritten or cleared by the next stall or fire on that output. ptr banks of inactive domains never change.
- Simultaneous events: all four outputs update independently in the same cycle. A fire and a new request on the same output in one cycle produce back-to-back grants, with the new pointer applied the next cycle.
- Reset (asserted at any time, including mid-stall):
  - All ptr banks go to 0 and lock_vld goes to 0, asynchronously.
  - While reset is low: out_val=0, in_rdy=0, sel*=0, regardless of inputs.
  - The first grant after deassertion uses ptr=0.
- Security labelling: every port except sd carries domain sd; sd is public.

Decomposition:
- Shared package: NPORTS=4, DEST_W=2, NDOMAINS, ptr/index type (2-bit), domain type.
- Sub-module vc_rr_arb4: combinational 4-way round-robin priority select.
  - Inputs: req[3:0], ptr[1:0]. Outputs: gnt_val, gnt_idx[1:0].
  - Instantiated once per output.
- Top level holds the pointer banks, lock registers, handshake logic and reset forcing.

Test Plan:
- Reset release, in_val=4'b1111, all in_dest=1, out_rdy=4'b1111:
  - Cycle 0: sel1=0, in_rdy=4'b0001.
  - Then sel1=1, 2, 3, 0 on successive cycles (pointer wrap).
- Stall lock, ptr[0][2]=0:
  - Inputs 1 and 3 request output 2 with out_rdy[2]=0 for 3 cycles: sel2 stays 1, in_rdy=0, out_val[2]=1.
  - out_rdy[2]=1: input 1 fires; next cycle sel2=3.
- Full permutation: in_dest={0,3,2,1} (in3..in0), all val, all rdy:
  - out_val=4'b1111, sel0=3, sel1=0, sel2=1, sel3=2, in_rdy=4'b1111 every cycle.
- Domain isolation:
  - sd=0: two fires on output 0 from inputs 0 and 1 leave ptr[0][0]=2.
  - Switch sd=1 with inputs 0 and 2 requesting output 0: sel0=0 (ptr[1][0]=0).
  - Back to sd=0: sel0=2.
- Mid-stall reset: lock held on output 3 (input 2) with reset asserted between edges:
  - Outputs go to 0 immediately.
  - After release, input 0 and input 2 both requesting output 3 gives sel3=0.
- Locked input drops val while out_rdy=0: out_val[j]=0 that cycle; next cycle the lock is clear and normal round-robin resumes.
